// File: rtl/rca_seq_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit ripple-carry slice reused per nibble, LSB nibble first.
// Optional SUB_EN macro adds a 'sub' input that latches ~b and forces carry-in to 1 (a - b).
module rca_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   busy
`ifdef SUB_EN
   ,
   input  logic                   sub
`endif
);

   localparam int WIDTH = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             carry_reg, carry_next;
   logic             cout_reg, cout_next;
   logic             sub_mode;

   logic [3:0]       a_nib, b_nib, rca_sum;
   logic [4:0]       rca_c;

`ifdef SUB_EN
   assign sub_mode = sub;
`else
   assign sub_mode = 1'b0;
`endif

   // The single shared 4-bit ripple-carry slice, fed by the current nibble.
   assign a_nib    = a_reg[{idx_reg, 2'b00} +: 4];
   assign b_nib    = b_reg[{idx_reg, 2'b00} +: 4];
   assign rca_c[0] = carry_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_fa
         assign rca_sum[gi]  = a_nib[gi] ^ b_nib[gi] ^ rca_c[gi];
         assign rca_c[gi+1]  = (a_nib[gi] & b_nib[gi]) | (rca_c[gi] & (a_nib[gi] ^ b_nib[gi]));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sum_next   = sum_reg;
      idx_next   = idx_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_next     = a;
               b_next     = sub_mode ? ~b : b;
               carry_next = sub_mode ? 1'b1 : cin;
               idx_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            busy                             = 1'b1;
            sum_next[{idx_reg, 2'b00} +: 4]  = rca_sum;
            carry_next                       = rca_c[4];
            if (idx_reg == LAST_IDX) begin
               cout_next  = rca_c[4];
               state_next = DONE;
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         idx_reg   <= idx_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: a 4-nibble and a 1-nibble instance checked against
// plain-arithmetic add/subtract results, with handshake timing and reset checks.
module tb_rca_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy, sub;
   logic [15:0] a, b, sum;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1, sub1;
   logic [3:0]  a1, b1, sum1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rca_seq_ctrl #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
`ifdef SUB_EN
      , .sub(sub)
`endif
   );

   rca_seq_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
      .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SUB_EN
      , .sub(sub1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the 4-nibble instance. 'hold' cycles of backpressure are applied
   // once the result is up, with junk offered on the input side meanwhile.
   task automatic do_op4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input int hold, input string name);
      logic [16:0] expv;
      logic [15:0] held_sum;
      logic        held_cout;
      int          lat, busy_cnt, ready_bad;
      bit          seen;
      expv = sv ? (17'(av) + 17'(~bv) + 17'd1) : (17'(av) + 17'(bv) + 17'(cv));
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      tick();                       // accepting edge (counted as edge 1)
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 1; busy_cnt = 0; ready_bad = 0; seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin
            seen = 1;
            break;
         end
         if (busy) busy_cnt++;
         if (in_ready) ready_bad++;
         tick();
         lat++;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL %s timeout: out_valid never rose within 50 cycles", name); end
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL %s latency: got %0d edges, want 5", name, lat); end
      checks++;
      if (busy_cnt !== 4) begin errors++; $display("FAIL %s busy_cycles: got %0d want 4", name, busy_cnt); end
      checks++;
      if (ready_bad !== 0) begin errors++; $display("FAIL %s in_ready_during_run: got %0d high cycles want 0", name, ready_bad); end
      checks++;
      if (sum !== expv[15:0]) begin errors++; $display("FAIL %s sum: got %h want %h", name, sum, expv[15:0]); end
      checks++;
      if (cout !== expv[16]) begin errors++; $display("FAIL %s cout: got %b want %b", name, cout, expv[16]); end
      held_sum = sum; held_cout = cout;
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
         tick();
         checks++;
         if (out_valid !== 1'b1 || sum !== held_sum || cout !== held_cout || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s backpressure: got valid=%b sum=%h cout=%b rdy=%b busy=%b want 1 %h %b 0 0",
                     name, out_valid, sum, cout, in_ready, busy, held_sum, held_cout);
         end
      end
      // Offering operands on the handshake edge must not start a new operation.
      in_valid = (hold > 0); out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_in_done: got %b want 0", name, in_ready); end
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_handshake: got valid=%b rdy=%b busy=%b want 0 1 0", name, out_valid, in_ready, busy);
      end
      $display("op %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b (model %h %b) lat=%0d", name, av, bv, cv, sv,
               held_sum, held_cout, expv[15:0], expv[16], lat);
   endtask

   task automatic do_op1(input logic [3:0] av, input logic [3:0] bv, input logic cv, input string name);
      logic [4:0] expv;
      int         lat;
      expv = 5'(av) + 5'(bv) + 5'(cv);
      a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 1;
      checks++;
      if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL %s run_cycle: got busy=%b valid=%b want 1 0", name, busy1, out_valid1);
      end
      for (int i = 0; i < 20 && !out_valid1; i++) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d edges, want 2", name, lat); end
      checks++;
      if (sum1 !== expv[3:0] || cout1 !== expv[4]) begin
         errors++; $display("FAIL %s result: got %h/%b want %h/%b", name, sum1, cout1, expv[3:0], expv[4]);
      end
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      checks++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
         errors++; $display("FAIL %s after_handshake: got rdy=%b valid=%b want 1 0", name, in_ready1, out_valid1);
      end
      $display("op %s: a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", name, av, bv, cv, sum1, cout1, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
      in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
      tick(); tick();
      checks++;
      if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || sum !== 16'h0 || cout !== 0) begin
         errors++; $display("FAIL reset4: got rdy=%b valid=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
                            in_ready, out_valid, busy, sum, cout);
      end
      checks++;
      if (in_ready1 !== 1 || out_valid1 !== 0 || busy1 !== 0 || sum1 !== 4'h0 || cout1 !== 0) begin
         errors++; $display("FAIL reset1: got rdy=%b valid=%b busy=%b sum=%h cout=%b want 1 0 0 0 0",
                            in_ready1, out_valid1, busy1, sum1, cout1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      do_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "ffff_plus_1");
      do_op4(16'h1234, 16'h4321, 1'b1, 1'b0, 0, "1234_plus_4321_c1");
   endtask

   task automatic test_backpressure();
      do_op4(16'h8000, 16'h8001, 1'b1, 1'b0, 3, "backpressure");
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL backpressure_idle: got rdy=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      do_op4(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, "pre_reset");
      a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();              // now in RUN with idx=2
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || sum !== 16'h0 || cout !== 0) begin
         errors++; $display("FAIL reset_mid_run: got rdy=%b valid=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
                            in_ready, out_valid, busy, sum, cout);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got valid=%b busy=%b want 0 0", out_valid, busy);
         end
      end
      do_op4(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         do_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_nibbles1();
      do_op1(4'hF, 4'h1, 1'b1, "n1_f_plus_1_c1");
      for (int i = 0; i < 6; i++) begin
         do_op1(4'($urandom), 4'($urandom), 1'($urandom), "n1_random");
      end
   endtask

   task automatic test_sub();
`ifdef SUB_EN
      do_op4(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_5_minus_7");
      do_op4(16'h0007, 16'h0005, 1'b1, 1'b1, 0, "sub_7_minus_5");
      for (int i = 0; i < 6; i++) begin
         do_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, "sub_random");
      end
`else
      $display("SUB_EN not defined: subtract scenario skipped");
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_nibbles1();
      test_sub();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
